step_clk_gen: RTL and testbench

- Upstream companion of the CPU clock controller.
- Converts the raw single-step push button and the clock-mode slide switch into clean, glitch-free `manual_clk` and `auto_en` levels. The clock controller consumes these directly.
- One debounced press yields exactly one fixed-width `manual_clk` high pulse, regardless of how long the button is held.
- A press counter is exported for LED debug display.

---
 rtl/step_clk_gen.sv | 192 +++++++++++++++++++
 tb/tb_step_clk_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clk_gen.sv
// Single-step clock front end: synchronises and debounces the step button and
// the mode switch, and turns each accepted press into one fixed-width
// manual_clk pulse for the CPU clock controller.

// Two-flop synchroniser for one asynchronous input.
module step_clk_sync (
  input  logic raw_clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module step_clk_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES    = 1000
) (
  input  logic        raw_clk,
  input  logic        rst,
  input  logic        btn,
  input  logic        mode_sw,
  output logic        manual_clk,
  output logic        auto_en,
  output logic        busy,
  output logic [15:0] step_count
);
  localparam int NUM_SYNC = 2;
  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    PULSE,
    HOLD,
    RELEASE_DB
  } state_t;

  // bit 0 = button, bit 1 = mode switch
  logic [NUM_SYNC-1:0] raw_in;
  logic [NUM_SYNC-1:0] sync_q;
  logic                btn_s;
  logic                mode_s;

  assign raw_in = {mode_sw, btn};
  assign btn_s  = sync_q[0];
  assign mode_s = sync_q[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SYNC; gi++) begin : g_sync
      step_clk_sync u_sync (
        .raw_clk (raw_clk),
        .rst     (rst),
        .d       (raw_in[gi]),
        .q       (sync_q[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mode switch debounce
  // ---------------------------------------------------------------------------
  logic [31:0] mcnt;
  logic        auto_en_q;

  // Count consecutive cycles where the synchronised switch disagrees with the
  // accepted level; any agreement restarts the count, so short glitches die.
  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      mcnt      <= '0;
      auto_en_q <= 1'b0;
    end else if (mode_s == auto_en_q) begin
      mcnt <= '0;
    end else if (mcnt == DB_LAST) begin
      mcnt      <= '0;
      auto_en_q <= ~auto_en_q;
    end else begin
      mcnt <= mcnt + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Button FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mclk_q, mclk_d;
  logic        busy_q;
  logic        step_inc;
  logic [15:0] step_count_q;

  // Next-state: press debounce, fixed-width pulse, then a debounced release
  // before the next press can be seen. The pulse phase ignores the button
  // and the mode so it always runs to full width.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mclk_d   = mclk_q;
    step_inc = 1'b0;
    case (state_q)
      IDLE: begin
        mclk_d = 1'b0;
        if (btn_s && auto_en_q) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d  = PULSE;
          cnt_d    = '0;
          mclk_d   = 1'b1;
          step_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          mclk_d  = 1'b0;
        end else begin
          cnt_d  = cnt_q + 32'd1;
          mclk_d = 1'b1;
        end
      end
      HOLD: begin
        mclk_d = 1'b0;
        if (!btn_s) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        mclk_d = 1'b0;
        if (btn_s) begin
          state_d = HOLD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        mclk_d  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; busy is derived from the next
  // state so it lines up exactly with the state register.
  always_ff @(posedge raw_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      step_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mclk_q       <= mclk_d;
      busy_q       <= (state_d != IDLE);
      step_count_q <= step_count_q + 16'(step_inc);
    end
  end

  assign manual_clk = mclk_q;
  assign auto_en    = auto_en_q;
  assign busy       = busy_q;
  assign step_count = step_count_q;
endmodule

// File: tb/tb_step_clk_gen.sv
// Bench for step_clk_gen with short debounce/pulse lengths. Expected step
// counts are queued when a press is driven; a forked monitor pops them as
// manual_clk pulses appear and checks each pulse width.
module tb_step_clk_gen;
  localparam int DB = 4;
  localparam int PC = 3;

  logic        raw_clk;
  logic        rst;
  logic        btn;
  logic        mode_sw;
  logic        manual_clk;
  logic        auto_en;
  logic        busy;
  logic [15:0] step_count;

  int          checks;
  int          errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_count;

  step_clk_gen #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PC)) dut (
    .raw_clk    (raw_clk),
    .rst        (rst),
    .btn        (btn),
    .mode_sw    (mode_sw),
    .manual_clk (manual_clk),
    .auto_en    (auto_en),
    .busy       (busy),
    .step_count (step_count)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge raw_clk);
      #1;
    end
  endtask

  // Pops one expected count per rising manual_clk; checks width on the fall.
  task automatic monitor();
    logic        prev;
    int          hl;
    logic [15:0] e;
    prev = 1'b0;
    hl   = 0;
    forever begin
      @(negedge raw_clk);
      if (!rst) begin
        prev = 1'b0;
        hl   = 0;
      end else begin
        if (manual_clk && !prev) begin
          hl = 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got pulse with step_count=%0d, want no pulse", step_count);
          end else begin
            e = exp_q.pop_front();
            if (step_count !== e) begin
              errors++;
              $display("FAIL pulse_step_count: got %0d want %0d", step_count, e);
            end
          end
        end else if (manual_clk) begin
          hl++;
        end else if (prev) begin
          checks++;
          if (hl != PC) begin
            errors++;
            $display("FAIL pulse_width: got %0d want %0d", hl, PC);
          end
        end
        prev = manual_clk;
      end
    end
  endtask

  task automatic test_reset();
    logic bad;
    bad = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn     = 1'($urandom_range(0, 1));
      mode_sw = 1'($urandom_range(0, 1));
      tick();
      if ({manual_clk, auto_en, busy, step_count} !== 19'd0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero output during reset, want all 0");
    end
    btn     = 1'b0;
    mode_sw = 1'b0;
    tick();
    rst = 1'b1;
    tick(10);
    checks++;
    if ({manual_clk, auto_en, busy, step_count} !== 19'd0) begin
      errors++;
      $display("FAIL reset_release: got mc=%b ae=%b busy=%b sc=%0d, want all 0",
               manual_clk, auto_en, busy, step_count);
    end
  endtask

  task automatic test_mode_accept();
    logic want;
    mode_sw = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      want = (e >= 5);
      checks++;
      if (auto_en !== want) begin
        errors++;
        $display("FAIL mode_accept edge %0d: got auto_en=%b want %b", e, auto_en, want);
      end
    end
    // 2-cycle glitch toward 0 must be rejected
    mode_sw = 1'b0;
    tick(2);
    mode_sw = 1'b1;
    want = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (auto_en !== want) want = 1'bx;
    end
    checks++;
    if (want !== 1'b1) begin
      errors++;
      $display("FAIL mode_glitch: got auto_en change, want auto_en held at 1");
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b1101100;  // applied MSB first: 1,1,0,1,1,0,0
    for (int i = 6; i >= 0; i--) begin
      btn = pat[i];
      tick();
    end
    btn = 1'b0;
    tick(8);
    checks++;
    if (step_count !== exp_count || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject: got sc=%0d busy=%b want sc=%0d busy=0", step_count, busy, exp_count);
    end
  endtask

  task automatic test_clean_press();
    logic want;
    for (int p = 0; p < 2; p++) begin
      exp_count = exp_count + 16'd1;
      exp_q.push_back(exp_count);
      btn = 1'b1;
      for (int e = 0; e < 20; e++) begin
        tick();
        want = (e >= 6 && e <= 8);
        checks++;
        if (manual_clk !== want) begin
          errors++;
          $display("FAIL press%0d_edge%0d: got manual_clk=%b want %b", p, e, manual_clk, want);
        end
      end
      checks++;
      if (step_count !== exp_count) begin
        errors++;
        $display("FAIL press%0d_count: got %0d want %0d", p, step_count, exp_count);
      end
      btn = 1'b0;
      tick(10);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL press%0d_release: got busy=%b want 0", p, busy);
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [5:0] pat;
    exp_count = exp_count + 16'd1;
    exp_q.push_back(exp_count);
    btn = 1'b1;
    tick(14);
    pat = 6'b010010;  // 0,1,0,0,1,0 while in HOLD/RELEASE_DB
    for (int i = 5; i >= 0; i--) begin
      btn = pat[i];
      tick();
    end
    btn = 1'b0;
    tick(12);
    checks++;
    if (step_count !== exp_count || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce: got sc=%0d busy=%b want sc=%0d busy=0", step_count, busy, exp_count);
    end
  endtask

  task automatic test_gating();
    logic bad;
    mode_sw = 1'b0;
    tick(8);
    checks++;
    if (auto_en !== 1'b0) begin
      errors++;
      $display("FAIL gate_mode_off: got auto_en=%b want 0", auto_en);
    end
    bad = 1'b0;
    btn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0 || manual_clk !== 1'b0) bad = 1'b1;
    end
    btn = 1'b0;
    tick(5);
    checks++;
    if (bad || step_count !== exp_count) begin
      errors++;
      $display("FAIL gate_press: got busy/pulse activity or sc=%0d, want idle and sc=%0d", step_count, exp_count);
    end
  endtask

  task automatic test_reset_mid_pulse();
    mode_sw = 1'b1;
    tick(8);
    checks++;
    if (auto_en !== 1'b1) begin
      errors++;
      $display("FAIL rmp_mode_on: got auto_en=%b want 1", auto_en);
    end
    exp_q.push_back(exp_count + 16'd1);
    btn = 1'b1;
    tick(8);  // edges 0..7: manual_clk high since edge 6, now in its 2nd high cycle
    checks++;
    if (manual_clk !== 1'b1) begin
      errors++;
      $display("FAIL rmp_pulse_high: got manual_clk=%b want 1", manual_clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (manual_clk !== 1'b0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL rmp_async_drop: got mc=%b sc=%0d want mc=0 sc=0", manual_clk, step_count);
    end
    exp_count = 16'd0;
    btn = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(12);
    checks++;
    if (auto_en !== 1'b1 || step_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmp_after: got ae=%b sc=%0d busy=%b want ae=1 sc=0 busy=0", auto_en, step_count, busy);
    end
  endtask

  task automatic test_wrap();
    force dut.step_count_q = 16'hFFFF;
    tick();
    release dut.step_count_q;
    tick();
    checks++;
    if (step_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h want ffff", step_count);
    end
    exp_count = 16'h0000;
    exp_q.push_back(exp_count);
    btn = 1'b1;
    tick(15);
    btn = 1'b0;
    tick(10);
    checks++;
    if (step_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap: got %h want 0000", step_count);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_count = 16'd0;
    rst       = 1'b0;
    btn       = 1'b0;
    mode_sw   = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_mode_accept();
    test_bounce();
    test_clean_press();
    test_release_bounce();
    test_gating();
    test_reset_mid_pulse();
    test_wrap();
    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d expected pulses unseen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
